banco_registros_param: RTL and testbench

Parametrised register bank for the datapath: two combinational read ports, one synchronous write port, configurable word width and depth. It is the successor to the fixed 4×16 bank and adds an optional hard-wired zero register, optional write-to-read bypass, and a sequential clear engine that zeroes the bank one register per cycle without a global reset. It sits between the instruction decoder, which drives the selects, and the ALU, which consumes A/B and produces E.

---
 rtl/br_pkg.sv | 14 +
 rtl/br_limpeza.sv | 64 ++++++
 rtl/banco_registros_param.sv | 96 +++++++++
 tb/tb_banco_registros_param.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/br_pkg.sv
// Shared types and constants for the parametrised register bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package br_pkg;

    // Clear engine states: idle, or walking the array zeroing one register per cycle.
    typedef enum logic {
        OCIOSO,
        LIMPANDO
    } estado_limpeza_t;

    localparam int BITS_PALAVRA_PADRAO = 16;

endpackage

// File: rtl/br_limpeza.sv
// Sequential clear engine: after a Limpa request, emits one register index per cycle.
// Latency: Ocupado rises one edge after Limpa; busy for num_registros cycles.
// Backpressure: none; Limpa is ignored while busy, and callers must treat Ocupado as a write stall.
//
// Ports: clock, reset (sync, active-high), Limpa (start request) ->
//        Ocupado (engine active), idx (register being cleared this cycle), clr_en (clear strobe).
module br_limpeza
    import br_pkg::*;
#(
    parameter int end_registros = 3,
    parameter int num_registros = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     Limpa,
    output logic                     Ocupado,
    output logic [end_registros-1:0] idx,
    output logic                     clr_en
);

    localparam logic [end_registros-1:0] ULTIMO_IDX = end_registros'(num_registros - 1);

    estado_limpeza_t estado;
    estado_limpeza_t prox_estado;
    logic [end_registros-1:0] prox_idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= OCIOSO;
            idx    <= '0;
        end else begin
            estado <= prox_estado;
            idx    <= prox_idx;
        end
    end

    always_comb begin
        prox_estado = estado;
        prox_idx    = idx;
        Ocupado     = 1'b0;
        clr_en      = 1'b0;
        case (estado)
            OCIOSO: begin
                if (Limpa) begin
                    prox_estado = LIMPANDO;
                    prox_idx    = '0;
                end
            end
            LIMPANDO: begin
                Ocupado  = 1'b1;
                clr_en   = 1'b1;
                // Incrementing past the last index wraps back to 0 on its own.
                prox_idx = idx + 1'b1;
                if (idx == ULTIMO_IDX) begin
                    prox_estado = OCIOSO;
                end
            end
            default: begin
                prox_estado = OCIOSO;
            end
        endcase
    end

endmodule

// File: rtl/banco_registros_param.sv
// Parametrised register bank: two combinational read ports, one synchronous write port, sequential clear.
// Latency: reads combinational; writes land at the next edge (same-cycle visible with BYPASS).
// Backpressure: writes presented while Ocupado are dropped and flagged on Erro_Escrita for one cycle.
//
// Ports: clock, reset (sync, active-high), Hab_Escrita/Sel_SC/E (write), Sel_SA/Sel_SB (reads),
//        Limpa (start clear) -> A, B (read data), Ocupado (clear active), Erro_Escrita (rejected write).
module banco_registros_param
    import br_pkg::*;
#(
    parameter int bits_palavra  = BITS_PALAVRA_PADRAO,
    parameter int end_registros = 3,
    parameter int num_registros = 8,
    parameter bit R0_ZERO       = 1'b1,
    parameter bit BYPASS        = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     Hab_Escrita,
    input  logic [end_registros-1:0] Sel_SA,
    input  logic [end_registros-1:0] Sel_SB,
    input  logic [end_registros-1:0] Sel_SC,
    input  logic [bits_palavra-1:0]  E,
    input  logic                     Limpa,
    output logic [bits_palavra-1:0]  A,
    output logic [bits_palavra-1:0]  B,
    output logic                     Ocupado,
    output logic                     Erro_Escrita
);

    generate
        if (num_registros != (1 << end_registros)) begin : g_checa_param
            $error("banco_registros_param: num_registros must equal 2**end_registros");
        end
    endgenerate

    logic [bits_palavra-1:0]  regs [num_registros];
    logic [end_registros-1:0] idx;
    logic                     clr_en;
    logic                     escrita_aceita;
    logic                     escrita_efetiva;

    br_limpeza #(
        .end_registros (end_registros),
        .num_registros (num_registros)
    ) u_limpeza (
        .clock   (clock),
        .reset   (reset),
        .Limpa   (Limpa),
        .Ocupado (Ocupado),
        .idx     (idx),
        .clr_en  (clr_en)
    );

    assign escrita_aceita  = Hab_Escrita && !Ocupado && !reset;
    // Accepted writes to a hard-wired zero register commit nothing, but are not errors either.
    assign escrita_efetiva = escrita_aceita && !(R0_ZERO && (Sel_SC == '0));

    // Priority: reset, then the clear engine, then the write port.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < num_registros; i++) begin
                regs[i] <= '0;
            end
            Erro_Escrita <= 1'b0;
        end else begin
            Erro_Escrita <= Hab_Escrita && Ocupado;
            if (clr_en) begin
                regs[idx] <= '0;
            end else if (escrita_efetiva) begin
                regs[Sel_SC] <= E;
            end
        end
    end

    // Bypass is applied first so the R0 override below always wins.
    always_comb begin
        A = regs[Sel_SA];
        if (BYPASS && escrita_aceita && (Sel_SC == Sel_SA)) begin
            A = E;
        end
        if (R0_ZERO && (Sel_SA == '0)) begin
            A = '0;
        end
    end

    always_comb begin
        B = regs[Sel_SB];
        if (BYPASS && escrita_aceita && (Sel_SC == Sel_SB)) begin
            B = E;
        end
        if (R0_ZERO && (Sel_SB == '0)) begin
            B = '0;
        end
    end

endmodule

// File: tb/tb_banco_registros_param.sv
module tb_banco_registros_param;

    logic        clock;
    logic        reset;
    logic        Hab_Escrita;
    logic [2:0]  Sel_SA;
    logic [2:0]  Sel_SB;
    logic [2:0]  Sel_SC;
    logic [15:0] E;
    logic        Limpa;
    logic [15:0] A;
    logic [15:0] B;
    logic        Ocupado;
    logic        Erro_Escrita;

    banco_registros_param dut (
        .clock        (clock),
        .reset        (reset),
        .Hab_Escrita  (Hab_Escrita),
        .Sel_SA       (Sel_SA),
        .Sel_SB       (Sel_SB),
        .Sel_SC       (Sel_SC),
        .E            (E),
        .Limpa        (Limpa),
        .A            (A),
        .B            (B),
        .Ocupado      (Ocupado),
        .Erro_Escrita (Erro_Escrita)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;

    // Reference model: register contents, clear engine busy flag/position, error flag.
    logic [15:0] m [8];
    bit          busy_m;
    int          cidx_m;
    bit          err_m;

    // Expected combinational read of one address given the current inputs.
    function automatic logic [15:0] exp_rd(input logic [2:0] addr);
        if (addr == 3'd0) return 16'h0000;
        if (Hab_Escrita && !busy_m && !reset && Sel_SC == addr) return E;
        return m[addr];
    endfunction

    // Advance the model by one edge using the inputs now applied, then step the DUT.
    task automatic tick();
        if (reset) begin
            for (int i = 0; i < 8; i++) m[i] = 16'h0000;
            busy_m = 0;
            cidx_m = 0;
            err_m  = 0;
        end else begin
            err_m = Hab_Escrita && busy_m;
            if (busy_m) begin
                m[cidx_m] = 16'h0000;
                cidx_m++;
                if (cidx_m == 8) begin
                    busy_m = 0;
                    cidx_m = 0;
                end
            end else begin
                if (Hab_Escrita && Sel_SC != 3'd0) m[Sel_SC] = E;
                if (Limpa) begin
                    busy_m = 1;
                    cidx_m = 0;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; Hab_Escrita = 0; Limpa = 0;
        Sel_SA = 0; Sel_SB = 0; Sel_SC = 0; E = 0;
    endtask

    task automatic write_reg(input logic [2:0] addr, input logic [15:0] val);
        Hab_Escrita = 1; Sel_SC = addr; E = val;
        tick();
        Hab_Escrita = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
        #1;
        total++; if (Ocupado !== 1'b0) begin $display("FAIL reset_ocupado got %b want 0", Ocupado); end else passed++;
        total++; if (Erro_Escrita !== 1'b0) begin $display("FAIL reset_erro got %b want 0", Erro_Escrita); end else passed++;
        for (int i = 0; i < 8; i++) begin
            Sel_SA = 3'(i); Sel_SB = 3'(7 - i);
            #1;
            total++; if (A !== 16'h0000) begin $display("FAIL reset_A[%0d] got %h want 0000", i, A); end else passed++;
            total++; if (B !== 16'h0000) begin $display("FAIL reset_B[%0d] got %h want 0000", 7 - i, B); end else passed++;
        end
    endtask

    task automatic test_basic_write();
        Hab_Escrita = 1; Sel_SC = 3; E = 16'hA5A5; Sel_SA = 3; Sel_SB = 2;
        #1;
        total++; if (A !== 16'hA5A5) begin $display("FAIL bypass_A got %h want a5a5", A); end else passed++;
        total++; if (B !== 16'h0000) begin $display("FAIL bypass_other_B got %h want 0000", B); end else passed++;
        tick();
        Hab_Escrita = 0; E = 16'h5A5A;
        #1;
        total++; if (A !== 16'hA5A5) begin $display("FAIL stored_A got %h want a5a5", A); end else passed++;
    endtask

    task automatic test_r0();
        Hab_Escrita = 1; Sel_SC = 0; E = 16'hFFFF; Sel_SA = 0; Sel_SB = 0;
        #1;
        total++; if (A !== 16'h0000) begin $display("FAIL r0_bypass_A got %h want 0000", A); end else passed++;
        total++; if (B !== 16'h0000) begin $display("FAIL r0_bypass_B got %h want 0000", B); end else passed++;
        tick();
        Hab_Escrita = 0;
        #1;
        total++; if (A !== 16'h0000) begin $display("FAIL r0_stored_A got %h want 0000", A); end else passed++;
        total++; if (Erro_Escrita !== 1'b0) begin $display("FAIL r0_erro got %b want 0", Erro_Escrita); end else passed++;
    endtask

    task automatic test_full_clear();
        for (int i = 1; i < 8; i++) write_reg(3'(i), 16'(i));
        Limpa = 1;
        tick();
        for (int c = 1; c <= 8; c++) begin
            // A second request mid-sequence must not restart it.
            Limpa = (c == 2);
            Sel_SA = 2; Sel_SB = 5;
            #1;
            total++; if (Ocupado !== 1'b1) begin $display("FAIL clear_ocupado cyc %0d got %b want 1", c, Ocupado); end else passed++;
            if (c == 4) begin
                total++; if (A !== 16'h0000) begin $display("FAIL clear_reg2 got %h want 0000", A); end else passed++;
                total++; if (B !== 16'h0005) begin $display("FAIL clear_reg5 got %h want 0005", B); end else passed++;
            end
            tick();
        end
        Limpa = 0;
        #1;
        total++; if (Ocupado !== 1'b0) begin $display("FAIL clear_done_ocupado got %b want 0", Ocupado); end else passed++;
        for (int i = 0; i < 8; i++) begin
            Sel_SA = 3'(i);
            #1;
            total++; if (A !== 16'h0000) begin $display("FAIL clear_after_A[%0d] got %h want 0000", i, A); end else passed++;
        end
    endtask

    task automatic test_write_during_clear();
        write_reg(6, 16'h7777);
        Limpa = 1;
        tick();
        Limpa = 0;
        tick();
        tick();
        Hab_Escrita = 1; Sel_SC = 6; E = 16'h1234; Sel_SA = 6;
        #1;
        total++; if (A !== 16'h7777) begin $display("FAIL busy_no_bypass got %h want 7777", A); end else passed++;
        tick();
        Hab_Escrita = 0;
        #1;
        total++; if (Erro_Escrita !== 1'b1) begin $display("FAIL erro_pulse got %b want 1", Erro_Escrita); end else passed++;
        tick();
        total++; if (Erro_Escrita !== 1'b0) begin $display("FAIL erro_drop got %b want 0", Erro_Escrita); end else passed++;
        for (int n = 0; n < 20 && Ocupado; n++) tick();
        total++; if (Ocupado !== 1'b0) begin $display("FAIL wdc_timeout ocupado got %b want 0", Ocupado); end else passed++;
        #1;
        total++; if (A !== 16'h0000) begin $display("FAIL wdc_reg6 got %h want 0000", A); end else passed++;
    endtask

    task automatic test_simultaneous();
        Hab_Escrita = 1; Sel_SC = 1; E = 16'h00FF; Limpa = 1; Sel_SA = 1;
        tick();
        Hab_Escrita = 0; Limpa = 0;
        #1;
        total++; if (A !== 16'h00FF) begin $display("FAIL simul_k got %h want 00ff", A); end else passed++;
        total++; if (Ocupado !== 1'b1) begin $display("FAIL simul_ocupado got %b want 1", Ocupado); end else passed++;
        tick();
        tick();
        total++; if (A !== 16'h0000) begin $display("FAIL simul_k2 got %h want 0000", A); end else passed++;
        for (int n = 0; n < 20 && busy_m; n++) tick();
    endtask

    task automatic test_reset_mid_clear();
        write_reg(3, 16'hBEEF);
        write_reg(7, 16'hCAFE);
        Limpa = 1;
        tick();
        Limpa = 0;
        tick();
        tick();
        reset = 1;
        tick();
        reset = 0;
        #1;
        total++; if (Ocupado !== 1'b0) begin $display("FAIL rmc_ocupado got %b want 0", Ocupado); end else passed++;
        for (int i = 0; i < 8; i++) begin
            Sel_SA = 3'(i);
            #1;
            total++; if (A !== 16'h0000) begin $display("FAIL rmc_A[%0d] got %h want 0000", i, A); end else passed++;
        end
        Hab_Escrita = 1; Sel_SC = 4; E = 16'h4321; Sel_SB = 4;
        tick();
        Hab_Escrita = 0;
        #1;
        total++; if (B !== 16'h4321) begin $display("FAIL rmc_write got %h want 4321", B); end else passed++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset       = ($urandom_range(0, 60) == 0);
            Limpa       = ($urandom_range(0, 15) == 0);
            Hab_Escrita = ($urandom_range(0, 2) != 0);
            Sel_SA      = 3'($urandom_range(0, 7));
            Sel_SB      = 3'($urandom_range(0, 7));
            Sel_SC      = ($urandom_range(0, 1) == 0) ? Sel_SA : 3'($urandom_range(0, 7));
            E           = 16'($urandom);
            #1;
            total++; if (A !== exp_rd(Sel_SA)) begin $display("FAIL rand_A cyc %0d got %h want %h", c, A, exp_rd(Sel_SA)); end else passed++;
            total++; if (B !== exp_rd(Sel_SB)) begin $display("FAIL rand_B cyc %0d got %h want %h", c, B, exp_rd(Sel_SB)); end else passed++;
            total++; if (Ocupado !== busy_m) begin $display("FAIL rand_ocupado cyc %0d got %b want %b", c, Ocupado, busy_m); end else passed++;
            total++; if (Erro_Escrita !== err_m) begin $display("FAIL rand_erro cyc %0d got %b want %b", c, Erro_Escrita, err_m); end else passed++;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) m[i] = 16'h0000;
        busy_m = 0;
        cidx_m = 0;
        err_m  = 0;
        test_reset();
        test_basic_write();
        test_r0();
        test_full_clear();
        test_write_during_clear();
        test_simultaneous();
        test_reset_mid_clear();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
